// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// FSM state encoding and the fixed start-to-done latency.
package mul_div_unit_pkg;

  localparam int MDU_WIDTH   = 32;
  localparam int MDU_LATENCY = MDU_WIDTH + 2;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PREP = 2'b01,
    RUN  = 2'b10,
    FIX  = 2'b11
  } state_e;

endpackage

// File: rtl/mul_div_unit_if.sv
// Control/result bundle between the control unit (master) and the
// multiply/divide unit (slave).
interface mul_div_unit_if
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) ();

  // start is a request accepted only while busy is low (unit in IDLE);
  // while busy is high it is ignored, not held. done is a one-cycle pulse
  // marking the edge on which hi/lo took the new result.
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  state_e           state;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  busy, done, hi, lo, state
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output busy, done, hi, lo, state
  );

endinterface

// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers:
// shift-add multiply and restoring divide on unsigned magnitudes.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  mul_div_unit_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e             state;
  op_e                op_r;
  logic [WIDTH-1:0]   a_r, b_r, ma, mb;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;
  logic               neg_lo, neg_hi, div_zero;

  logic               is_div, is_signed;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum, rem_sh;
  logic [WIDTH-1:0]   rem_sub, quo_fix, rem_fix;
  logic               rem_ge;
  logic [2*WIDTH-1:0] acc_next, prod;

  assign bus.state = state;

  always_comb begin
    is_div    = (op_r == OP_DIV) || (op_r == OP_DIVU);
    is_signed = (op_r == OP_MULT) || (op_r == OP_DIV);
    mag_a     = (is_signed && a_r[WIDTH-1]) ? -a_r : a_r;
    mag_b     = (is_signed && b_r[WIDTH-1]) ? -b_r : b_r;
    // Multiply: acc = {partial product, remaining multiplier bits}.
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, ma};
    // Divide: acc = {partial remainder, dividend bits becoming quotient}.
    // The shifted remainder needs WIDTH+1 bits for the compare, but once
    // it is >= the divisor the difference always fits in WIDTH bits.
    rem_sh    = acc[2*WIDTH-1:WIDTH-1];
    rem_ge    = rem_sh >= {1'b0, mb};
    rem_sub   = rem_sh[WIDTH-1:0] - mb;
    if (is_div)
      acc_next = rem_ge ? {rem_sub, acc[WIDTH-2:0], 1'b1} : {acc[2*WIDTH-2:0], 1'b0};
    else
      acc_next = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
    prod      = neg_lo ? -acc : acc;
    quo_fix   = div_zero ? '1  : (neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
    rem_fix   = div_zero ? a_r : (neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      op_r     <= OP_MULT;
      a_r      <= '0;
      b_r      <= '0;
      ma       <= '0;
      mb       <= '0;
      acc      <= '0;
      cnt      <= '0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      div_zero <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.hi   <= '0;
      bus.lo   <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.hi_we) bus.hi <= bus.wdata;
          if (bus.lo_we) bus.lo <= bus.wdata;
          if (bus.start) begin
            op_r     <= op_e'(bus.op);
            a_r      <= bus.a;
            b_r      <= bus.b;
            bus.busy <= 1'b1;
            state    <= PREP;
          end
        end
        PREP: begin
          ma       <= mag_a;
          mb       <= mag_b;
          acc      <= is_div ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
          cnt      <= '0;
          neg_lo   <= is_signed && (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
          neg_hi   <= is_signed && is_div && a_r[WIDTH-1];
          div_zero <= is_div && (b_r == '0);
          state    <= RUN;
        end
        RUN: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= FIX;
        end
        FIX: begin
          if (is_div) begin
            bus.hi <= rem_fix;
            bus.lo <= quo_fix;
          end else begin
            bus.hi <= prod[2*WIDTH-1:WIDTH];
            bus.lo <= prod[WIDTH-1:0];
          end
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed and randomized bench for mul_div_unit; expected {hi,lo} results
// are queued at issue time and popped when done pulses.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;

  mul_div_unit_if #(.WIDTH(W)) bus ();

  mul_div_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] exp_q[$];

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*W-1:0] model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [2*W-1:0] sp;
    logic signed [W-1:0]   sa, sb, q, r;
    sa = a;
    sb = b;
    case (op)
      2'b00: begin
        sp = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
        return sp;
      end
      2'b01: return {{W{1'b0}}, a} * {{W{1'b0}}, b};
      2'b10: begin
        if (b == '0) return {a, {W{1'b1}}};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        q = sa / sb;
        r = sa % sb;
        return {r, q};
      end
      default: begin
        if (b == '0) return {a, {W{1'b1}}};
        return {a % b, a / b};
      end
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    exp_q.push_back(model(op, a, b));
    tick();
    bus.start = 1'b0;
    check("busy_after_start", {63'b0, bus.busy}, 64'd1);
  endtask

  task automatic wait_result(input string tag);
    int cyc;
    logic [2*W-1:0] exp;
    cyc = 0;
    while (!bus.done && cyc < 100) begin
      tick();
      cyc++;
      if (cyc == MDU_LATENCY - 1) check({tag, "_busy_at_fix"}, {63'b0, bus.busy}, 64'd1);
    end
    check({tag, "_done"}, {63'b0, bus.done}, 64'd1);
    check({tag, "_latency"}, 64'(cyc), 64'(MDU_LATENCY));
    check({tag, "_busy_low"}, {63'b0, bus.busy}, 64'd0);
    check({tag, "_queue"}, {63'b0, exp_q.size() != 0}, 64'd1);
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    check({tag, "_result"}, {bus.hi, bus.lo}, exp);
  endtask

  initial begin
    logic [W-1:0] lo_before;
    logic         seen_done;
    logic [1:0]   rop;
    logic [W-1:0] ra, rb;

    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = '0;
    tick();
    tick();
    check("reset_busy",  {63'b0, bus.busy}, 64'd0);
    check("reset_done",  {63'b0, bus.done}, 64'd0);
    check("reset_hilo",  {bus.hi, bus.lo}, 64'd0);
    check("reset_state", {62'b0, bus.state}, {62'b0, IDLE});
    reset = 1'b0;
    tick();

    issue(OP_MULT, 32'hFFFFFFFD, 32'd7);          wait_result("mult_neg");
    tick();
    check("done_pulse", {63'b0, bus.done}, 64'd0);
    issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);  wait_result("multu_max");
    issue(OP_DIV, 32'hFFFFFFF9, 32'd2);           wait_result("div_neg");
    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);    wait_result("div_ovf");
    issue(OP_DIVU, 32'h00001234, 32'd0);          wait_result("divu_zero");
    issue(OP_DIV, 32'hFFFFFF00, 32'd0);           wait_result("div_zero");
    // back-to-back: start in the done cycle
    issue(OP_DIV, 32'd100, 32'hFFFFFFF9);         wait_result("div_b2b_a");
    issue(OP_DIVU, 32'hDEADBEEF, 32'd16);         wait_result("div_b2b_b");

    for (int i = 0; i < 8; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300));
      issue(rop, ra, rb);
      wait_result("random");
    end

    tick();
    bus.hi_we = 1'b1;
    bus.wdata = 32'hCAFEF00D;
    lo_before = bus.lo;
    tick();
    bus.hi_we = 1'b0;
    check("mthi", {bus.hi, bus.lo}, {32'hCAFEF00D, lo_before});
    bus.lo_we = 1'b1;
    bus.wdata = 32'h0BADBEEF;
    tick();
    bus.lo_we = 1'b0;
    check("mtlo", {bus.hi, bus.lo}, {32'hCAFEF00D, 32'h0BADBEEF});

    bus.lo_we = 1'b1;
    bus.wdata = 32'h00000055;
    issue(OP_MULTU, 32'd2, 32'd3);
    bus.lo_we = 1'b0;
    check("write_with_start", {32'b0, bus.lo}, 64'h55);
    wait_result("write_then_fix");

    issue(OP_MULTU, 32'd5, 32'd6);
    lo_before = bus.lo;
    repeat (9) tick();
    bus.start = 1'b1;
    bus.op    = OP_DIVU;
    bus.a     = 32'd9;
    bus.b     = 32'd3;
    bus.lo_we = 1'b1;
    bus.wdata = 32'h000000AA;
    tick();
    bus.start = 1'b0;
    bus.lo_we = 1'b0;
    check("busy_ignores_start", {63'b0, bus.busy}, 64'd1);
    check("busy_ignores_mtlo", {32'b0, bus.lo}, {32'b0, lo_before});
    repeat (9) tick();
    reset = 1'b1;
    #2;
    check("async_reset_busy", {63'b0, bus.busy}, 64'd0);
    check("async_reset_hilo", {bus.hi, bus.lo}, 64'd0);
    check("async_reset_state", {62'b0, bus.state}, {62'b0, IDLE});
    exp_q.delete();
    tick();
    reset = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done) seen_done = 1'b1;
    end
    check("no_done_after_abort", {63'b0, seen_done}, 64'd0);
    issue(OP_MULTU, 32'd5, 32'd6);
    wait_result("rerun_5x6");
    check("rerun_value", {bus.hi, bus.lo}, 64'd30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
